axi_ram_responder_64bit: RTL and testbench
==========================================

// Module: axi_ram_responder_64bit
// PURPOSE
//  AXI4 slave (responder) backed by an on-chip RAM. It answers the DDR test write/read masters in place of ddr3_core_64 port 1.
//  Purpose: fast simulation and board bring-up without the DDR PHY.
//  INCR and FIXED bursts are supported. One outstanding transaction per direction; the write and read paths run independently.
// PARAMETERS
//  DATA_WIDTH  64  AXI data width in bits; wstrb width is DATA_WIDTH/8
//  ID_WIDTH    8   width of awid/bid/arid/rid
//  ADDR_WIDTH  32  width of awaddr/araddr (byte address)
//  MEM_AW      10  RAM depth is 2**MEM_AW words of DATA_WIDTH bits
// PORTS
//  clk                 in   1           AXI clock; all logic on posedge
//  rst_n               in   1           asynchronous active-low reset
//  awid/arid           in   ID_WIDTH    write/read request ID
//  awaddr/araddr       in   ADDR_WIDTH  write/read start byte address
//  awlen/arlen         in   8           burst length minus 1
//  awsize/arsize       in   3           beat size (log2 bytes)
//  awburst/arburst     in   2           00 FIXED, 01 INCR, others are errors
//  awvalid/arvalid     in   1           address valid
//  awready/arready     out  1           address accepted
//  wdata               in   DATA_WIDTH  write data
//  wstrb               in   DATA_WIDTH/8  byte enables
//  wlast, wvalid       in   1           last write beat; write data valid
//  wready              out  1           write data accepted
//  bid, bresp          out  ID_WIDTH,2  write response ID and status
//  bvalid              out  1           write response valid
//  bready              in   1           write response accepted
//  rid, rresp          out  ID_WIDTH,2  read ID and status
//  rdata               out  DATA_WIDTH  read data
//  rlast, rvalid       out  1           last read beat; read data valid
//  rready              in   1           read data accepted
// BEHAVIOUR
//  Reset values: awready=1, arready=1, wready=0, bvalid=0, rvalid=0, rlast=0, bresp/rresp=00, bid/rid=0, rdata=0.
//  RAM contents are not reset.
//  Word index = addr[MEM_AW+2:3] (for DATA_WIDTH=64). Upper address bits are ignored, so accesses alias modulo the RAM depth.
//  Error condition: burst is not 00/01, or size != log2(DATA_WIDTH/8). On error the RAM is not written, rdata=0, and the response is 10 (SLVERR).
//  Otherwise the response is 00 (OKAY).
//  Write FSM W_IDLE -> W_DATA -> W_RESP -> W_IDLE:
//   - W_IDLE: awready=1. On awvalid, latch id/addr/len/err, then awready=0 and wready=1.
//   - W_DATA: every wvalid&wready beat writes the RAM under wstrb. INCR advances the index by 1 and wraps at 2**MEM_AW-1 -> 0; FIXED holds it.
//     After len+1 beats, wready=0 and go to W_RESP.
//     If wlast disagrees with the beat count, the beat count wins and bresp=10 for that burst.
//   - W_RESP: bvalid=1 and bid=latched id, held until bready. awready=1 again in the cycle after the handshake.
//  Read FSM R_IDLE -> R_FETCH -> R_DATA -> R_IDLE:
//   - R_IDLE: arready=1. On arvalid, latch id/addr/len/err.
//   - R_FETCH: one cycle of RAM read latency.
//   - R_DATA: rvalid=1. rdata, rid and rresp are stable until rready. rlast=1 on beat len.
//     On handshake, return to R_FETCH for the next beat, or go to R_IDLE after the last beat.
//   - Throughput is 1 beat per 2 cycles. First rvalid is 2 cycles after the AR handshake.
//  Simultaneous write and read to the same word in one cycle: the read returns the old data.
//  len=0 is a single beat (rlast asserted with the first beat). len=255 is 256 beats with no early termination.
//  rst_n low mid-burst: both FSMs return to IDLE at once and all valids drop. Partial RAM writes remain.
//  awvalid/arvalid that arrive while busy wait (ready=0). They are never dropped.
// STRUCTURE
//  Shared package axi_test_pkg: BURST_FIXED=2'b00, BURST_INCR=2'b01, RESP_OKAY=2'b00, RESP_SLVERR=2'b10, and the FSM state enums.
//  One sub-module: axi_ram_sdp, a simple dual-port RAM.
//   - Ports: wclk, we, wbe, waddr, wdata, raddr, rdata, with 1-cycle registered read.
//   - Read-before-write for a same-address collision.
//  The two FSMs and the address counters stay in this file.
// TESTING
//  - INCR write, awaddr=0x40, len=3, data 0x11..0x44 -> words 8..11 written; one B with bid=awid and bresp=00. Read back the same range -> 4 beats in order, rlast on the 4th.
//  - wstrb=0x0F over word 0xFFFF_FFFF_FFFF_FFFF with wdata=0 -> reads back 0xFFFF_FFFF_0000_0000.
//  - INCR len=3 starting at word 1022 (MEM_AW=10) -> writes words 1022, 1023, 0, 1.
//  - FIXED len=3 read -> same word returned 4 times. Burst=10 -> bresp=10, RAM unchanged; reads return rdata=0, rresp=10.
//  - rready toggled randomly during a len=15 read, plus bready held low 20 cycles -> no beat lost or duplicated; bvalid stays high with no new awready.
//  - rst_n pulsed low at write beat 2 of 8 -> all valids are 0 next cycle; a new transaction after reset completes normally.

Source files
------------

// File: rtl/axi_test_pkg.sv
// Shared AXI encodings and FSM state types for the RAM-backed responder.
// Imported by the responder top and its testbench-facing pieces.
package axi_test_pkg;

   localparam logic [1:0] BURST_FIXED = 2'b00;
   localparam logic [1:0] BURST_INCR  = 2'b01;
   localparam logic [1:0] RESP_OKAY   = 2'b00;
   localparam logic [1:0] RESP_SLVERR = 2'b10;

   typedef enum logic [1:0] {
      W_IDLE,
      W_DATA,
      W_RESP
   } w_state_e;

   typedef enum logic [1:0] {
      R_IDLE,
      R_FETCH,
      R_DATA
   } r_state_e;

   function automatic logic req_err(
      input logic [1:0] burst,
      input logic [2:0] size,
      input logic [2:0] size_ok
   );
      return ((burst != BURST_FIXED) && (burst != BURST_INCR))
          || (size != size_ok);
   endfunction

endpackage

// File: rtl/axi_ram_responder_64bit_if.sv
// AXI4 bus bundle between a test master and the RAM responder.
// master drives requests and write data; slave drives ready/response.
interface axi_ram_responder_64bit_if #(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 32
);
   logic [ID_WIDTH-1:0]     awid;
   logic [ADDR_WIDTH-1:0]   awaddr;
   logic [7:0]              awlen;
   logic [2:0]              awsize;
   logic [1:0]              awburst;
   logic                    awvalid;
   logic                    awready;
   logic [DATA_WIDTH-1:0]   wdata;
   logic [DATA_WIDTH/8-1:0] wstrb;
   logic                    wlast;
   logic                    wvalid;
   logic                    wready;
   logic [ID_WIDTH-1:0]     bid;
   logic [1:0]              bresp;
   logic                    bvalid;
   logic                    bready;
   logic [ID_WIDTH-1:0]     arid;
   logic [ADDR_WIDTH-1:0]   araddr;
   logic [7:0]              arlen;
   logic [2:0]              arsize;
   logic [1:0]              arburst;
   logic                    arvalid;
   logic                    arready;
   logic [ID_WIDTH-1:0]     rid;
   logic [1:0]              rresp;
   logic [DATA_WIDTH-1:0]   rdata;
   logic                    rlast;
   logic                    rvalid;
   logic                    rready;

   modport master (
      output awid, awaddr, awlen, awsize, awburst, awvalid,
      input  awready,
      output wdata, wstrb, wlast, wvalid,
      input  wready,
      input  bid, bresp, bvalid,
      output bready,
      output arid, araddr, arlen, arsize, arburst, arvalid,
      input  arready,
      input  rid, rresp, rdata, rlast, rvalid,
      output rready
   );

   modport slave (
      input  awid, awaddr, awlen, awsize, awburst, awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready,
      input  arid, araddr, arlen, arsize, arburst, arvalid,
      output arready,
      output rid, rresp, rdata, rlast, rvalid,
      input  rready
   );

endinterface

// File: rtl/axi_ram_sdp.sv
// Simple dual-port RAM: byte-enabled write, registered read.
// A same-address read and write in one cycle returns the old word.
module axi_ram_sdp #(
   parameter int DW = 64,
   parameter int AW = 10
) (
   input  logic            wclk,
   input  logic            we,
   input  logic [DW/8-1:0] wbe,
   input  logic [AW-1:0]   waddr,
   input  logic [DW-1:0]   wdata,
   input  logic [AW-1:0]   raddr,
   output logic [DW-1:0]   rdata
);

   logic [DW-1:0] mem_q [2**AW];
   logic [DW-1:0] rd_q;

   always_ff @(posedge wclk) begin
      if (we) begin
         for (int i = 0; i < DW/8; i++) begin
            if (wbe[i]) begin
               mem_q[waddr][i*8 +: 8] <= wdata[i*8 +: 8];
            end
         end
      end
      rd_q <= mem_q[raddr];
   end

   assign rdata = rd_q;

endmodule

// File: rtl/axi_ram_responder_64bit.sv
// AXI4 responder backed by on-chip RAM; stands in for the DDR port.
// Independent write and read FSMs, one outstanding burst each.
module axi_ram_responder_64bit
   import axi_test_pkg::*;
#(
   parameter int DATA_WIDTH = 64,
   parameter int ID_WIDTH   = 8,
   parameter int ADDR_WIDTH = 32,
   parameter int MEM_AW     = 10
) (
   input logic                        clk,
   input logic                        rst_n,
   axi_ram_responder_64bit_if.slave   s
);

   localparam int          NB      = DATA_WIDTH / 8;
   localparam int          OFFS    = $clog2(NB);
   localparam logic [2:0]  SIZE_OK = 3'(OFFS);
   localparam logic [MEM_AW-1:0] IDX_ONE = MEM_AW'(1);

   w_state_e              w_state_q, w_state_d;
   logic [ID_WIDTH-1:0]   w_id_q, w_id_d;
   logic [MEM_AW-1:0]     w_idx_q, w_idx_d;
   logic [7:0]            w_len_q, w_len_d;
   logic [7:0]            w_cnt_q, w_cnt_d;
   logic                  w_err_q, w_err_d;
   logic                  w_fix_q, w_fix_d;
   logic                  w_bad_q, w_bad_d;

   r_state_e              r_state_q, r_state_d;
   logic [ID_WIDTH-1:0]   r_id_q, r_id_d;
   logic [MEM_AW-1:0]     r_idx_q, r_idx_d;
   logic [7:0]            r_len_q, r_len_d;
   logic [7:0]            r_cnt_q, r_cnt_d;
   logic                  r_err_q, r_err_d;
   logic                  r_fix_q, r_fix_d;
   logic [DATA_WIDTH-1:0] rdata_q, rdata_d;

   logic                  ram_we;
   logic [DATA_WIDTH-1:0] ram_rdata;
   logic                  w_last_beat;

   assign w_last_beat = (w_cnt_q == w_len_q);

   always_comb begin
      w_state_d = w_state_q;
      w_id_d    = w_id_q;
      w_idx_d   = w_idx_q;
      w_len_d   = w_len_q;
      w_cnt_d   = w_cnt_q;
      w_err_d   = w_err_q;
      w_fix_d   = w_fix_q;
      w_bad_d   = w_bad_q;
      ram_we    = 1'b0;
      unique case (w_state_q)
         W_IDLE: begin
            if (s.awvalid) begin
               w_id_d    = s.awid;
               w_idx_d   = s.awaddr[MEM_AW+OFFS-1:OFFS];
               w_len_d   = s.awlen;
               w_cnt_d   = 8'd0;
               w_err_d   = req_err(s.awburst, s.awsize, SIZE_OK);
               w_fix_d   = (s.awburst == BURST_FIXED);
               w_bad_d   = 1'b0;
               w_state_d = W_DATA;
            end
         end
         W_DATA: begin
            if (s.wvalid) begin
               ram_we  = !w_err_q;
               w_cnt_d = w_cnt_q + 8'd1;
               if (!w_fix_q) w_idx_d = w_idx_q + IDX_ONE;
               // beat count ends the burst; a stray wlast only flags it
               if (s.wlast != w_last_beat) w_bad_d = 1'b1;
               if (w_last_beat) w_state_d = W_RESP;
            end
         end
         W_RESP: begin
            if (s.bready) w_state_d = W_IDLE;
         end
         default: w_state_d = W_IDLE;
      endcase
   end

   always_comb begin
      r_state_d = r_state_q;
      r_id_d    = r_id_q;
      r_idx_d   = r_idx_q;
      r_len_d   = r_len_q;
      r_cnt_d   = r_cnt_q;
      r_err_d   = r_err_q;
      r_fix_d   = r_fix_q;
      rdata_d   = rdata_q;
      unique case (r_state_q)
         R_IDLE: begin
            if (s.arvalid) begin
               r_id_d    = s.arid;
               r_idx_d   = s.araddr[MEM_AW+OFFS-1:OFFS];
               r_len_d   = s.arlen;
               r_cnt_d   = 8'd0;
               r_err_d   = req_err(s.arburst, s.arsize, SIZE_OK);
               r_fix_d   = (s.arburst == BURST_FIXED);
               r_state_d = R_FETCH;
            end
         end
         R_FETCH: begin
            rdata_d   = r_err_q ? '0 : ram_rdata;
            r_state_d = R_DATA;
         end
         R_DATA: begin
            if (s.rready) begin
               r_cnt_d = r_cnt_q + 8'd1;
               if (!r_fix_q) r_idx_d = r_idx_q + IDX_ONE;
               r_state_d = (r_cnt_q == r_len_q) ? R_IDLE : R_FETCH;
            end
         end
         default: r_state_d = R_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         w_state_q <= W_IDLE;
         w_id_q    <= '0;
         w_idx_q   <= '0;
         w_len_q   <= '0;
         w_cnt_q   <= '0;
         w_err_q   <= 1'b0;
         w_fix_q   <= 1'b0;
         w_bad_q   <= 1'b0;
         r_state_q <= R_IDLE;
         r_id_q    <= '0;
         r_idx_q   <= '0;
         r_len_q   <= '0;
         r_cnt_q   <= '0;
         r_err_q   <= 1'b0;
         r_fix_q   <= 1'b0;
         rdata_q   <= '0;
      end else begin
         w_state_q <= w_state_d;
         w_id_q    <= w_id_d;
         w_idx_q   <= w_idx_d;
         w_len_q   <= w_len_d;
         w_cnt_q   <= w_cnt_d;
         w_err_q   <= w_err_d;
         w_fix_q   <= w_fix_d;
         w_bad_q   <= w_bad_d;
         r_state_q <= r_state_d;
         r_id_q    <= r_id_d;
         r_idx_q   <= r_idx_d;
         r_len_q   <= r_len_d;
         r_cnt_q   <= r_cnt_d;
         r_err_q   <= r_err_d;
         r_fix_q   <= r_fix_d;
         rdata_q   <= rdata_d;
      end
   end

   // read address runs one step ahead so data is ready in R_FETCH
   axi_ram_sdp #(
      .DW (DATA_WIDTH),
      .AW (MEM_AW)
   ) u_ram (
      .wclk  (clk),
      .we    (ram_we),
      .wbe   (s.wstrb),
      .waddr (w_idx_q),
      .wdata (s.wdata),
      .raddr (r_idx_d),
      .rdata (ram_rdata)
   );

   assign s.awready = (w_state_q == W_IDLE);
   assign s.wready  = (w_state_q == W_DATA);
   assign s.bvalid  = (w_state_q == W_RESP);
   assign s.bid     = w_id_q;
   assign s.bresp   = ((w_state_q == W_RESP) && (w_err_q || w_bad_q))
                      ? RESP_SLVERR : RESP_OKAY;

   assign s.arready = (r_state_q == R_IDLE);
   assign s.rvalid  = (r_state_q == R_DATA);
   assign s.rlast   = (r_state_q == R_DATA) && (r_cnt_q == r_len_q);
   assign s.rid     = r_id_q;
   assign s.rresp   = ((r_state_q == R_DATA) && r_err_q)
                      ? RESP_SLVERR : RESP_OKAY;
   assign s.rdata   = rdata_q;

   logic unused_ok;
   assign unused_ok = ^{s.awaddr[ADDR_WIDTH-1:MEM_AW+OFFS],
                        s.awaddr[OFFS-1:0],
                        s.araddr[ADDR_WIDTH-1:MEM_AW+OFFS],
                        s.araddr[OFFS-1:0]};

endmodule

// File: tb/tb_axi_ram_responder_64bit.sv
// Randomized bench for the AXI RAM responder with a word-array reference.
// Drivers sample and drive on the falling edge.
module tb_axi_ram_responder_64bit;

   localparam int BOUND = 1000;

   logic clk;
   logic rst_n;
   int   checks;
   int   errors;
   bit   tmo;

   logic [63:0] mem_m [1024];
   logic [7:0]  km    [1024];

   logic [63:0] wbuf [$];
   logic [7:0]  sbuf [$];
   logic [63:0] rbuf [$];
   logic [1:0]  rrbuf [$];
   logic [7:0]  b_id;
   logic [1:0]  b_resp;
   bit          b_hold_ok;
   bit          r_last_ok;
   bit          r_stable_ok;
   int          r_lat;
   logic [7:0]  r_id;

   axi_ram_responder_64bit_if bus ();

   axi_ram_responder_64bit dut (
      .clk   (clk),
      .rst_n (rst_n),
      .s     (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic int widx(input logic [31:0] a, input int i,
                               input logic [1:0] bu);
      return (int'(a[12:3]) + ((bu == 2'b01) ? i : 0)) % 1024;
   endfunction

   function automatic logic [63:0] bmask(input logic [7:0] k);
      logic [63:0] m;
      for (int b = 0; b < 8; b++) m[8*b +: 8] = {8{k[b]}};
      return m;
   endfunction

   task automatic model_write(input logic [31:0] a, input int len,
                              input logic [2:0] sz, input logic [1:0] bu);
      int idx;
      if (bu > 2'b01 || sz != 3'd3) return;
      for (int i = 0; i <= len; i++) begin
         idx = widx(a, i, bu);
         for (int b = 0; b < 8; b++) begin
            if (sbuf[i][b]) begin
               mem_m[idx][8*b +: 8] = wbuf[i][8*b +: 8];
               km[idx][b] = 1'b1;
            end
         end
      end
   endtask

   task automatic axi_write(input logic [7:0] id, input logic [31:0] addr,
                            input logic [7:0] len, input logic [2:0] sz,
                            input logic [1:0] bu, input int bdelay,
                            input bit badlast);
      int n;
      b_hold_ok = 1'b1;
      @(negedge clk);
      bus.awid = id; bus.awaddr = addr; bus.awlen = len;
      bus.awsize = sz; bus.awburst = bu; bus.awvalid = 1'b1;
      n = 0;
      while (!bus.awready && n < BOUND) begin @(negedge clk); n++; end
      if (n >= BOUND) tmo = 1'b1;
      @(negedge clk);
      bus.awvalid = 1'b0;
      for (int i = 0; i <= int'(len); i++) begin
         bus.wdata  = wbuf[i];
         bus.wstrb  = sbuf[i];
         bus.wlast  = badlast ? (i == 0) : (i == int'(len));
         bus.wvalid = 1'b1;
         n = 0;
         while (!bus.wready && n < BOUND) begin @(negedge clk); n++; end
         if (n >= BOUND) tmo = 1'b1;
         @(negedge clk);
      end
      bus.wvalid = 1'b0;
      bus.wlast  = 1'b0;
      n = 0;
      while (!bus.bvalid && n < BOUND) begin @(negedge clk); n++; end
      if (n >= BOUND) tmo = 1'b1;
      for (int k = 0; k < bdelay; k++) begin
         @(negedge clk);
         if (!bus.bvalid || bus.awready) b_hold_ok = 1'b0;
      end
      b_id   = bus.bid;
      b_resp = bus.bresp;
      bus.bready = 1'b1;
      @(negedge clk);
      bus.bready = 1'b0;
   endtask

   task automatic axi_read(input logic [7:0] id, input logic [31:0] addr,
                           input logic [7:0] len, input logic [2:0] sz,
                           input logic [1:0] bu, input bit rnd);
      int n;
      int got;
      bit held;
      logic [63:0] hd;
      logic hl;
      rbuf = {};
      rrbuf = {};
      r_last_ok = 1'b1;
      r_stable_ok = 1'b1;
      @(negedge clk);
      bus.arid = id; bus.araddr = addr; bus.arlen = len;
      bus.arsize = sz; bus.arburst = bu; bus.arvalid = 1'b1;
      n = 0;
      while (!bus.arready && n < BOUND) begin @(negedge clk); n++; end
      if (n >= BOUND) tmo = 1'b1;
      r_lat = 0;
      do begin
         @(negedge clk);
         bus.arvalid = 1'b0;
         r_lat++;
      end while (!bus.rvalid && r_lat < BOUND);
      got = 0; n = 0; held = 1'b0; hd = '0; hl = 1'b0;
      while (got <= int'(len) && n < BOUND) begin
         bus.rready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         if (bus.rvalid) begin
            if (held && (bus.rdata !== hd || bus.rlast !== hl))
               r_stable_ok = 1'b0;
            if (bus.rready) begin
               rbuf.push_back(bus.rdata);
               rrbuf.push_back(bus.rresp);
               if (bus.rlast !== (got == int'(len))) r_last_ok = 1'b0;
               r_id = bus.rid;
               got++;
               held = 1'b0;
            end else begin
               held = 1'b1;
               hd = bus.rdata;
               hl = bus.rlast;
            end
         end
         @(negedge clk);
         n++;
      end
      bus.rready = 1'b0;
      if (n >= BOUND) tmo = 1'b1;
   endtask

   task automatic test_reset;
      checks++;
      if ({bus.awready, bus.arready, bus.wready, bus.bvalid,
           bus.rvalid, bus.rlast} !== 6'b110000) begin
         errors++;
         $display("FAIL reset_ctrl got %b want 110000",
                  {bus.awready, bus.arready, bus.wready, bus.bvalid,
                   bus.rvalid, bus.rlast});
      end
      checks++;
      if ({bus.bresp, bus.rresp, bus.bid, bus.rid} !== 20'h0) begin
         errors++;
         $display("FAIL reset_resp_id got %h want 0",
                  {bus.bresp, bus.rresp, bus.bid, bus.rid});
      end
      checks++;
      if (bus.rdata !== 64'h0) begin
         errors++;
         $display("FAIL reset_rdata got %h want 0", bus.rdata);
      end
   endtask

   task automatic test_incr;
      wbuf = {64'h11, 64'h22, 64'h33, 64'h44};
      sbuf = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      axi_write(8'h5A, 32'h40, 8'd3, 3'd3, 2'b01, 0, 1'b0);
      model_write(32'h40, 3, 3'd3, 2'b01);
      checks++;
      if ({b_id, b_resp} !== {8'h5A, 2'b00}) begin
         errors++;
         $display("FAIL incr_b got id %h resp %b want 5a 00", b_id, b_resp);
      end
      checks++;
      if (bus.awready !== 1'b1) begin
         errors++;
         $display("FAIL incr_awready_after_b got %b want 1", bus.awready);
      end
      axi_read(8'hA5, 32'h40, 8'd3, 3'd3, 2'b01, 1'b0);
      checks++;
      if (rbuf.size() != 4) begin
         errors++;
         $display("FAIL incr_beats got %0d want 4", rbuf.size());
      end
      for (int i = 0; i < rbuf.size(); i++) begin
         checks++;
         if (rbuf[i] !== 64'(17 * (i + 1)) || rrbuf[i] !== 2'b00) begin
            errors++;
            $display("FAIL incr_rdata[%0d] got %h/%b want %h/00",
                     i, rbuf[i], rrbuf[i], 64'(17 * (i + 1)));
         end
      end
      checks++;
      if (!r_last_ok || r_id !== 8'hA5 || r_lat != 2) begin
         errors++;
         $display("FAIL incr_rlast_rid_lat got %b %h %0d want 1 a5 2",
                  r_last_ok, r_id, r_lat);
      end
   endtask

   task automatic test_strobe;
      wbuf = {64'hFFFF_FFFF_FFFF_FFFF};
      sbuf = {8'hFF};
      axi_write(8'h01, 32'h28, 8'd0, 3'd3, 2'b01, 0, 1'b0);
      model_write(32'h28, 0, 3'd3, 2'b01);
      wbuf = {64'h0};
      sbuf = {8'h0F};
      axi_write(8'h02, 32'h28, 8'd0, 3'd3, 2'b01, 0, 1'b0);
      model_write(32'h28, 0, 3'd3, 2'b01);
      axi_read(8'h03, 32'h28, 8'd0, 3'd3, 2'b01, 1'b0);
      checks++;
      if (rbuf.size() != 1 || rbuf[0] !== 64'hFFFF_FFFF_0000_0000
          || mem_m[5] !== 64'hFFFF_FFFF_0000_0000 || !r_last_ok) begin
         errors++;
         $display("FAIL strobe got %h want ffffffff00000000",
                  (rbuf.size() > 0) ? rbuf[0] : 64'hx);
      end
   endtask

   task automatic test_wrap;
      logic [63:0] d [4];
      int w;
      wbuf = {}; sbuf = {};
      for (int i = 0; i < 4; i++) begin
         d[i] = {$urandom, $urandom};
         wbuf.push_back(d[i]);
         sbuf.push_back(8'hFF);
      end
      axi_write(8'h10, 32'(1022 * 8), 8'd3, 3'd3, 2'b01, 0, 1'b0);
      model_write(32'(1022 * 8), 3, 3'd3, 2'b01);
      for (int i = 0; i < 4; i++) begin
         w = (1022 + i) % 1024;
         axi_read(8'h11, 32'(w * 8), 8'd0, 3'd3, 2'b01, 1'b0);
         checks++;
         if (rbuf.size() != 1 || rbuf[0] !== d[i]) begin
            errors++;
            $display("FAIL wrap_word%0d got %h want %h", w,
                     (rbuf.size() > 0) ? rbuf[0] : 64'hx, d[i]);
         end
      end
   endtask

   task automatic test_fixed;
      logic [63:0] d;
      d = {$urandom, $urandom};
      wbuf = {64'h1, 64'h2, 64'h3, d};
      sbuf = {8'hFF, 8'hFF, 8'hFF, 8'hFF};
      axi_write(8'h20, 32'(20 * 8), 8'd3, 3'd3, 2'b00, 0, 1'b0);
      model_write(32'(20 * 8), 3, 3'd3, 2'b00);
      axi_read(8'h21, 32'(20 * 8), 8'd3, 3'd3, 2'b00, 1'b0);
      checks++;
      if (rbuf.size() != 4 || !r_last_ok) begin
         errors++;
         $display("FAIL fixed_beats got %0d last_ok %b want 4 1",
                  rbuf.size(), r_last_ok);
      end
      for (int i = 0; i < rbuf.size(); i++) begin
         checks++;
         if (rbuf[i] !== d) begin
            errors++;
            $display("FAIL fixed_rdata[%0d] got %h want %h", i, rbuf[i], d);
         end
      end
   endtask

   task automatic test_burst_err;
      wbuf = {64'hDEAD, 64'hBEEF};
      sbuf = {8'hFF, 8'hFF};
      axi_write(8'h30, 32'h40, 8'd1, 3'd3, 2'b10, 0, 1'b0);
      checks++;
      if (b_resp !== 2'b10 || b_id !== 8'h30) begin
         errors++;
         $display("FAIL err_burst_bresp got %b/%h want 10/30", b_resp, b_id);
      end
      axi_write(8'h31, 32'h40, 8'd1, 3'd2, 2'b01, 0, 1'b0);
      checks++;
      if (b_resp !== 2'b10) begin
         errors++;
         $display("FAIL err_size_bresp got %b want 10", b_resp);
      end
      axi_read(8'h32, 32'h40, 8'd1, 3'd3, 2'b01, 1'b0);
      checks++;
      if (rbuf.size() != 2 || rbuf[0] !== mem_m[8] || rbuf[1] !== mem_m[9])
      begin
         errors++;
         $display("FAIL err_ram_unchanged got %h %h want %h %h",
                  rbuf[0], rbuf[1], mem_m[8], mem_m[9]);
      end
      axi_read(8'h33, 32'h40, 8'd1, 3'd3, 2'b10, 1'b0);
      for (int i = 0; i < 2; i++) begin
         checks++;
         if (rbuf.size() != 2 || rbuf[i] !== 64'h0 || rrbuf[i] !== 2'b10)
         begin
            errors++;
            $display("FAIL err_read[%0d] got %h/%b want 0/10",
                     i, rbuf[i], rrbuf[i]);
         end
      end
      wbuf = {64'h5, 64'h6, 64'h7};
      sbuf = {8'hFF, 8'hFF, 8'hFF};
      axi_write(8'h34, 32'(600 * 8), 8'd2, 3'd3, 2'b01, 0, 1'b1);
      for (int i = 0; i < 3; i++) km[600 + i] = 8'h00;
      checks++;
      if (b_resp !== 2'b10 || bus.awready !== 1'b1) begin
         errors++;
         $display("FAIL wlast_mismatch got %b/%b want 10/1",
                  b_resp, bus.awready);
      end
   endtask

   task automatic test_backpressure;
      wbuf = {}; sbuf = {};
      for (int i = 0; i < 16; i++) begin
         wbuf.push_back({$urandom, $urandom});
         sbuf.push_back(8'hFF);
      end
      axi_write(8'h40, 32'(100 * 8), 8'd15, 3'd3, 2'b01, 20, 1'b0);
      model_write(32'(100 * 8), 15, 3'd3, 2'b01);
      checks++;
      if (!b_hold_ok || b_resp !== 2'b00 || b_id !== 8'h40) begin
         errors++;
         $display("FAIL bp_bhold got %b %b %h want 1 00 40",
                  b_hold_ok, b_resp, b_id);
      end
      axi_read(8'h41, 32'(100 * 8), 8'd15, 3'd3, 2'b01, 1'b1);
      checks++;
      if (rbuf.size() != 16 || !r_last_ok || !r_stable_ok
          || bus.rvalid !== 1'b0) begin
         errors++;
         $display("FAIL bp_read got n=%0d last %b stable %b rvalid %b",
                  rbuf.size(), r_last_ok, r_stable_ok, bus.rvalid);
      end
      for (int i = 0; i < rbuf.size(); i++) begin
         checks++;
         if (rbuf[i] !== mem_m[100 + i]) begin
            errors++;
            $display("FAIL bp_rdata[%0d] got %h want %h",
                     i, rbuf[i], mem_m[100 + i]);
         end
      end
   endtask

   task automatic test_random;
      logic [31:0] a;
      logic [7:0]  len;
      logic [1:0]  bu;
      bit          er;
      int          idx;
      logic [63:0] m;
      for (int t = 0; t < 12; t++) begin
         a   = {$urandom} & 32'hFFFF_FFF8;
         len = 8'($urandom_range(0, 7));
         bu  = ($urandom_range(0, 5) == 0) ? 2'b11
                                           : 2'($urandom_range(0, 1));
         er  = (bu == 2'b11);
         wbuf = {}; sbuf = {};
         for (int i = 0; i <= int'(len); i++) begin
            wbuf.push_back({$urandom, $urandom});
            sbuf.push_back(8'($urandom));
         end
         axi_write(8'(t), a, len, 3'd3, bu, 0, 1'b0);
         model_write(a, int'(len), 3'd3, bu);
         checks++;
         if (b_resp !== (er ? 2'b10 : 2'b00) || b_id !== 8'(t)) begin
            errors++;
            $display("FAIL rnd_b t%0d got %b/%h", t, b_resp, b_id);
         end
         axi_read(8'(t + 100), a, len, 3'd3, bu, 1'b1);
         checks++;
         if (rbuf.size() != int'(len) + 1 || !r_last_ok) begin
            errors++;
            $display("FAIL rnd_beats t%0d got %0d want %0d",
                     t, rbuf.size(), int'(len) + 1);
         end
         for (int i = 0; i < rbuf.size(); i++) begin
            idx = widx(a, i, bu);
            m = er ? 64'hFFFF_FFFF_FFFF_FFFF : bmask(km[idx]);
            checks++;
            if ((((rbuf[i] ^ (er ? 64'h0 : mem_m[idx])) & m) !== 64'h0)
                || rrbuf[i] !== (er ? 2'b10 : 2'b00)) begin
               errors++;
               $display("FAIL rnd_rdata t%0d[%0d] got %h/%b want %h mask %h",
                        t, i, rbuf[i], rrbuf[i], mem_m[idx], m);
            end
         end
      end
   endtask

   task automatic test_reset_midburst;
      int n;
      wbuf = {}; sbuf = {};
      for (int i = 0; i < 8; i++) begin
         wbuf.push_back({$urandom, $urandom});
         sbuf.push_back(8'hFF);
      end
      @(negedge clk);
      bus.awid = 8'h50; bus.awaddr = 32'(200 * 8); bus.awlen = 8'd7;
      bus.awsize = 3'd3; bus.awburst = 2'b01; bus.awvalid = 1'b1;
      n = 0;
      while (!bus.awready && n < BOUND) begin @(negedge clk); n++; end
      @(negedge clk);
      bus.awvalid = 1'b0;
      for (int i = 0; i < 2; i++) begin
         bus.wdata = wbuf[i]; bus.wstrb = 8'hFF;
         bus.wlast = 1'b0; bus.wvalid = 1'b1;
         @(negedge clk);
      end
      bus.wdata = wbuf[2];
      rst_n = 1'b0;
      @(negedge clk);
      bus.wvalid = 1'b0;
      checks++;
      if ({bus.awready, bus.arready, bus.wready, bus.bvalid, bus.rvalid}
          !== 5'b11000) begin
         errors++;
         $display("FAIL midrst_valids got %b want 11000",
                  {bus.awready, bus.arready, bus.wready, bus.bvalid,
                   bus.rvalid});
      end
      rst_n = 1'b1;
      model_write(32'(200 * 8), 1, 3'd3, 2'b01);
      km[202] = 8'h00;
      wbuf = {64'hCAFE_0001, 64'hCAFE_0002};
      sbuf = {8'hFF, 8'hFF};
      axi_write(8'h51, 32'(300 * 8), 8'd1, 3'd3, 2'b01, 0, 1'b0);
      model_write(32'(300 * 8), 1, 3'd3, 2'b01);
      checks++;
      if (b_resp !== 2'b00 || b_id !== 8'h51) begin
         errors++;
         $display("FAIL midrst_new_b got %b/%h want 00/51", b_resp, b_id);
      end
      axi_read(8'h52, 32'(300 * 8), 8'd1, 3'd3, 2'b01, 1'b0);
      checks++;
      if (rbuf.size() != 2 || rbuf[0] !== 64'hCAFE_0001
          || rbuf[1] !== 64'hCAFE_0002) begin
         errors++;
         $display("FAIL midrst_new_read got %h %h", rbuf[0], rbuf[1]);
      end
      axi_read(8'h53, 32'(200 * 8), 8'd1, 3'd3, 2'b01, 1'b0);
      checks++;
      if (rbuf.size() != 2 || rbuf[0] !== mem_m[200]
          || rbuf[1] !== mem_m[201]) begin
         errors++;
         $display("FAIL midrst_partial got %h %h want %h %h",
                  rbuf[0], rbuf[1], mem_m[200], mem_m[201]);
      end
   endtask

   initial begin
      checks = 0; errors = 0; tmo = 1'b0;
      for (int i = 0; i < 1024; i++) begin
         mem_m[i] = '0;
         km[i] = '0;
      end
      rst_n = 1'b0;
      bus.awid = '0; bus.awaddr = '0; bus.awlen = '0; bus.awsize = '0;
      bus.awburst = '0; bus.awvalid = 1'b0;
      bus.wdata = '0; bus.wstrb = '0; bus.wlast = 1'b0; bus.wvalid = 1'b0;
      bus.bready = 1'b0;
      bus.arid = '0; bus.araddr = '0; bus.arlen = '0; bus.arsize = '0;
      bus.arburst = '0; bus.arvalid = 1'b0; bus.rready = 1'b0;
      repeat (3) @(negedge clk);
      test_reset();
      rst_n = 1'b1;
      @(negedge clk);
      test_incr();
      test_strobe();
      test_wrap();
      test_fixed();
      test_burst_err();
      test_backpressure();
      test_random();
      test_reset_midburst();
      checks++;
      if (tmo) begin
         errors++;
         $display("FAIL handshake_timeout got expired want none");
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
